ahb_sink_master: RTL and testbench

AHB_SINK_MASTER -- requirements
Module: ahb_sink_master

---
 rtl/ahb_sink_master.sv | 157 +++++++++++++++
 tb/tb_ahb_sink_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sink_master.sv
// Bridges a valid/ready sink request port onto AHB-Lite as single NONSEQ transfers.
// Two-stage AP/DP pipeline; an ERROR response parks the pending address phase for replay.
module ahb_sink_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk_sink,
    input  logic                  i_rst_sink,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_err,
    output logic                  o_idle,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic                  o_hwrite,
    output logic [1:0]            o_htrans,
    output logic [2:0]            o_hsize,
    output logic [2:0]            o_hburst,
    output logic [DATA_WIDTH-1:0] o_hwdata,
    input  logic [DATA_WIDTH-1:0] i_hrdata,
    input  logic                  i_hready,
    input  logic                  i_hresp
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic {ST_RUN, ST_ERR} state_t;

    state_t state, state_nxt;

    logic                  ap_valid;
    logic [DATA_WIDTH-1:0] ap_wdata;
    logic                  dp_valid;
    logic                  dp_write;
    logic                  rp_valid;
    logic                  rp_write;
    logic [ADDR_WIDTH-1:0] rp_addr;
    logic [DATA_WIDTH-1:0] rp_wdata;
    logic                  accept;
    logic                  ap_done;
    logic                  dp_done;
    logic                  err_enter;
    logic                  err_exit;

    assign o_htrans = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign o_hsize  = 3'($clog2(DATA_WIDTH / 8));
    assign o_hburst = 3'b000;
    assign o_idle   = !ap_valid && !dp_valid && (state == ST_RUN) && !rp_valid;
    assign accept   = i_valid && o_ready;

    always_ff @(posedge i_clk_sink) begin
        if (i_rst_sink) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ERROR is two cycles: HREADY low with HRESP flags entry, HREADY high with HRESP retires the DP
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        ap_done   = 1'b0;
        dp_done   = 1'b0;
        err_enter = 1'b0;
        err_exit  = 1'b0;
        case (state)
            ST_RUN: begin
                o_ready = !ap_valid || i_hready;
                ap_done = ap_valid && i_hready;
                dp_done = dp_valid && i_hready;
                if (dp_valid && i_hresp && !i_hready) begin
                    err_enter = 1'b1;
                    state_nxt = ST_ERR;
                end
            end
            default: begin
                if (i_hready && i_hresp) begin
                    dp_done   = 1'b1;
                    err_exit  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk_sink) begin
        if (i_rst_sink) begin
            ap_valid   <= 1'b0;
            ap_wdata   <= '0;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            rp_valid   <= 1'b0;
            rp_write   <= 1'b0;
            rp_addr    <= '0;
            rp_wdata   <= '0;
            o_haddr    <= '0;
            o_hwrite   <= 1'b0;
            o_hwdata   <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_rd_valid <= 1'b0;
            o_err      <= 1'b0;

            if (dp_done) begin
                dp_valid   <= 1'b0;
                o_err      <= i_hresp;
                o_rd_valid <= !dp_write;
                if (!dp_write) begin
                    o_rd_data <= i_hresp ? '0 : i_hrdata;
                end
            end

            if (ap_done) begin
                dp_valid <= 1'b1;
                dp_write <= o_hwrite;
                o_hwdata <= ap_wdata;
            end

            // A request caught behind the failing DP (already in AP or accepted this edge) is parked
            if (err_enter) begin
                ap_valid <= 1'b0;
                rp_valid <= ap_valid || accept;
                if (ap_valid) begin
                    rp_addr  <= o_haddr;
                    rp_write <= o_hwrite;
                    rp_wdata <= ap_wdata;
                end else begin
                    rp_addr  <= i_addr;
                    rp_write <= i_rd0_wr1;
                    rp_wdata <= i_wr_data;
                end
            end else if (err_exit) begin
                ap_valid <= rp_valid;
                rp_valid <= 1'b0;
                if (rp_valid) begin
                    o_haddr  <= rp_addr;
                    o_hwrite <= rp_write;
                    ap_wdata <= rp_wdata;
                end
            end else if (accept) begin
                ap_valid <= 1'b1;
                o_haddr  <= i_addr;
                o_hwrite <= i_rd0_wr1;
                ap_wdata <= i_wr_data;
            end else if (ap_done) begin
                ap_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_sink_master.sv
// Directed scenarios for pipelining, wait states, ERROR replay and reset, followed by
// random traffic against a behavioural AHB slave with an in-order response scoreboard.
module tb_ahb_sink_master;
    logic        i_clk_sink;
    logic        i_rst_sink;
    logic        i_valid;
    logic        i_rd0_wr1;
    logic [31:0] i_addr;
    logic [31:0] i_wr_data;
    logic        o_ready;
    logic [31:0] o_rd_data;
    logic        o_rd_valid;
    logic        o_err;
    logic        o_idle;
    logic [31:0] o_haddr;
    logic        o_hwrite;
    logic [1:0]  o_htrans;
    logic [2:0]  o_hsize;
    logic [2:0]  o_hburst;
    logic [31:0] o_hwdata;
    logic [31:0] i_hrdata;
    logic        i_hready;
    logic        i_hresp;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } req_t;

    req_t        accepted_q[$];
    req_t        cur_req;
    req_t        front;
    logic [31:0] mem [16];
    logic        req_held;
    logic        slv_active;
    logic        slv_wr;
    logic [3:0]  slv_idx;
    logic [31:0] slv_data;
    int          slv_waits;
    logic        slv_err;
    logic        slv_err_stage;
    logic        due_valid;
    logic        due_read;
    logic        due_err;
    logic [31:0] due_data;
    int          accepted_count;
    int          completed_count;

    ahb_sink_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk_sink(i_clk_sink),
        .i_rst_sink(i_rst_sink),
        .i_valid(i_valid),
        .i_rd0_wr1(i_rd0_wr1),
        .i_addr(i_addr),
        .i_wr_data(i_wr_data),
        .o_ready(o_ready),
        .o_rd_data(o_rd_data),
        .o_rd_valid(o_rd_valid),
        .o_err(o_err),
        .o_idle(o_idle),
        .o_haddr(o_haddr),
        .o_hwrite(o_hwrite),
        .o_htrans(o_htrans),
        .o_hsize(o_hsize),
        .o_hburst(o_hburst),
        .o_hwdata(o_hwdata),
        .i_hrdata(i_hrdata),
        .i_hready(i_hready),
        .i_hresp(i_hresp)
    );

    initial begin
        i_clk_sink = 1'b0;
        forever #5 i_clk_sink = ~i_clk_sink;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then samples 2 time units after the closing edge
    task automatic applyStimulus(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic hr, input logic hresp, input logic [31:0] hrd);
        i_valid   = v;
        i_rd0_wr1 = wr;
        i_addr    = a;
        i_wr_data = d;
        i_hready  = hr;
        i_hresp   = hresp;
        i_hrdata  = hrd;
        @(posedge i_clk_sink);
        #2;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_rst_sink   = 1'b1;

        // Reset state
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("rst_htrans", o_htrans, 2'b00);
        checkOutput("rst_haddr", o_haddr, 0);
        checkOutput("rst_hwrite", o_hwrite, 0);
        checkOutput("rst_hwdata", o_hwdata, 0);
        checkOutput("rst_rd_data", o_rd_data, 0);
        checkOutput("rst_rd_valid", o_rd_valid, 0);
        checkOutput("rst_err", o_err, 0);
        checkOutput("rst_idle", o_idle, 1);
        checkOutput("rst_hsize", o_hsize, 3'd2);
        checkOutput("rst_hburst", o_hburst, 3'd0);
        i_rst_sink = 1'b0;
        checkOutput("rst_ready", o_ready, 1);

        // Single write
        applyStimulus(1, 1, 32'h100, 32'hDEADBEEF, 1, 0, 0);
        checkOutput("wr_htrans", o_htrans, 2'b10);
        checkOutput("wr_haddr", o_haddr, 32'h100);
        checkOutput("wr_hwrite", o_hwrite, 1);
        checkOutput("wr_idle_busy", o_idle, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("wr_dp_htrans", o_htrans, 2'b00);
        checkOutput("wr_hwdata", o_hwdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("wr_no_rd_valid", o_rd_valid, 0);
        checkOutput("wr_no_err", o_err, 0);
        checkOutput("wr_idle_back", o_idle, 1);

        // Back-to-back reads
        applyStimulus(1, 0, 32'h0, 0, 1, 0, 0);
        checkOutput("b2b_ap0_htrans", o_htrans, 2'b10);
        checkOutput("b2b_ap0_haddr", o_haddr, 32'h0);
        checkOutput("b2b_ap0_hwrite", o_hwrite, 0);
        applyStimulus(1, 0, 32'h4, 0, 1, 0, 0);
        checkOutput("b2b_ap1_htrans", o_htrans, 2'b10);
        checkOutput("b2b_ap1_haddr", o_haddr, 32'h4);
        applyStimulus(1, 0, 32'h8, 0, 1, 0, 32'h11);
        checkOutput("b2b_ap2_htrans", o_htrans, 2'b10);
        checkOutput("b2b_ap2_haddr", o_haddr, 32'h8);
        checkOutput("b2b_rv0", o_rd_valid, 1);
        checkOutput("b2b_rd0", o_rd_data, 32'h11);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h22);
        checkOutput("b2b_idle_htrans", o_htrans, 2'b00);
        checkOutput("b2b_rv1", o_rd_valid, 1);
        checkOutput("b2b_rd1", o_rd_data, 32'h22);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h33);
        checkOutput("b2b_rv2", o_rd_valid, 1);
        checkOutput("b2b_rd2", o_rd_data, 32'h33);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("b2b_rv_end", o_rd_valid, 0);
        checkOutput("b2b_idle", o_idle, 1);

        // Wait states on a read with a write queued in the address phase
        applyStimulus(1, 0, 32'h20, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h24, 32'hCAFE0001, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ws_htrans_hold", o_htrans, 2'b10);
        checkOutput("ws_haddr_hold", o_haddr, 32'h24);
        checkOutput("ws_hwrite_hold", o_hwrite, 1);
        checkOutput("ws_ready_low", o_ready, 0);
        checkOutput("ws_no_rv", o_rd_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ws_haddr_hold2", o_haddr, 32'h24);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ws_htrans_hold3", o_htrans, 2'b10);
        checkOutput("ws_no_rv3", o_rd_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h5555AAAA);
        checkOutput("ws_rv", o_rd_valid, 1);
        checkOutput("ws_rd", o_rd_data, 32'h5555AAAA);
        checkOutput("ws_htrans_idle", o_htrans, 2'b00);
        checkOutput("ws_hwdata", o_hwdata, 32'hCAFE0001);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("ws_rv_once", o_rd_valid, 0);
        checkOutput("ws_idle", o_idle, 1);

        // Two-cycle ERROR on a read with a write in the address phase
        applyStimulus(1, 0, 32'h40, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h44, 32'h12345678, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hBAD);
        checkOutput("err_htrans_idle", o_htrans, 2'b00);
        checkOutput("err_ready_low", o_ready, 0);
        checkOutput("err_idle_busy", o_idle, 0);
        checkOutput("err_no_strobe_yet", o_err, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'hBAD);
        checkOutput("err_pulse", o_err, 1);
        checkOutput("err_rv", o_rd_valid, 1);
        checkOutput("err_rd_zero", o_rd_data, 0);
        checkOutput("err_replay_htrans", o_htrans, 2'b10);
        checkOutput("err_replay_haddr", o_haddr, 32'h44);
        checkOutput("err_replay_hwrite", o_hwrite, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("err_pulse_end", o_err, 0);
        checkOutput("err_rv_end", o_rd_valid, 0);
        checkOutput("err_replay_hwdata", o_hwdata, 32'h12345678);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("err_idle", o_idle, 1);

        // Reset during the data phase of a read
        applyStimulus(1, 0, 32'h80, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        i_rst_sink = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h77);
        checkOutput("mrst_no_rv", o_rd_valid, 0);
        checkOutput("mrst_htrans", o_htrans, 2'b00);
        checkOutput("mrst_haddr", o_haddr, 0);
        checkOutput("mrst_hwdata", o_hwdata, 0);
        checkOutput("mrst_rd_data", o_rd_data, 0);
        checkOutput("mrst_idle", o_idle, 1);
        checkOutput("mrst_hsize", o_hsize, 3'd2);
        i_rst_sink = 1'b0;
        applyStimulus(1, 1, 32'h200, 32'hA5A5A5A5, 1, 0, 0);
        checkOutput("mrst_next_htrans", o_htrans, 2'b10);
        checkOutput("mrst_next_haddr", o_haddr, 32'h200);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("mrst_next_hwdata", o_hwdata, 32'hA5A5A5A5);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("mrst_next_idle", o_idle, 1);

        // Random traffic: the slave answers each completed address phase; every accepted
        // request must appear on the bus in order and yield exactly one response
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        req_held        = 1'b0;
        slv_active      = 1'b0;
        slv_wr          = 1'b0;
        slv_idx         = '0;
        slv_data        = '0;
        slv_waits       = 0;
        slv_err         = 1'b0;
        slv_err_stage   = 1'b0;
        due_valid       = 1'b0;
        due_read        = 1'b0;
        due_err         = 1'b0;
        due_data        = '0;
        accepted_count  = 0;
        completed_count = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checkOutput("rnd_rd_valid", o_rd_valid, due_valid && due_read);
            checkOutput("rnd_err", o_err, due_valid && due_err);
            if (due_valid && due_read) checkOutput("rnd_rd_data", o_rd_data, due_data);
            due_valid = 1'b0;

            if (!slv_active || slv_waits > 0) begin
                i_hready = !slv_active;
                i_hresp  = 1'b0;
            end else if (slv_err) begin
                i_hready = slv_err_stage;
                i_hresp  = 1'b1;
            end else begin
                i_hready = 1'b1;
                i_hresp  = 1'b0;
            end
            i_hrdata = (slv_active && !slv_wr) ? mem[slv_idx] : $urandom;

            if (!req_held && cyc < 520 && $urandom_range(9) < 6) begin
                req_held     = 1'b1;
                cur_req.addr = 32'h1000 + 32'($urandom_range(15)) * 4;
                cur_req.wr   = 1'($urandom_range(1));
                cur_req.data = $urandom;
            end
            i_valid   = req_held;
            i_rd0_wr1 = cur_req.wr;
            i_addr    = cur_req.addr;
            i_wr_data = cur_req.data;
            #1;

            if (slv_active && i_hready) begin
                if (slv_wr) checkOutput("rnd_hwdata", o_hwdata, slv_data);
                due_valid = 1'b1;
                due_read  = !slv_wr;
                due_err   = slv_err;
                due_data  = slv_err ? 32'h0 : mem[slv_idx];
                if (slv_wr && !slv_err) mem[slv_idx] = slv_data;
                slv_active = 1'b0;
                completed_count++;
            end else if (slv_active) begin
                if (slv_waits > 0) slv_waits--;
                else if (slv_err) slv_err_stage = 1'b1;
            end

            if (o_htrans == 2'b10 && i_hready) begin
                checkOutput("rnd_ap_expected", accepted_q.size() != 0, 1);
                if (accepted_q.size() != 0) begin
                    front = accepted_q.pop_front();
                    checkOutput("rnd_haddr", o_haddr, front.addr);
                    checkOutput("rnd_hwrite", o_hwrite, front.wr);
                    slv_active    = 1'b1;
                    slv_wr        = o_hwrite;
                    slv_idx       = o_haddr[5:2];
                    slv_data      = front.data;
                    slv_waits     = $urandom_range(2);
                    slv_err       = ($urandom_range(4) == 0);
                    slv_err_stage = 1'b0;
                end
            end

            if (i_valid && o_ready) begin
                accepted_q.push_back(cur_req);
                accepted_count++;
                req_held = 1'b0;
            end
            @(posedge i_clk_sink);
            #2;
        end
        checkOutput("rnd_drain_idle", o_idle, 1);
        checkOutput("rnd_drain_queue", accepted_q.size(), 0);
        checkOutput("rnd_all_completed", completed_count, accepted_count);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
